// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file writeback port arbiter: register/word
// types, arbiter FSM state encoding and the default starvation limit.
package wb_port_arbiter_pkg;

    typedef logic [4:0]  rvga_reg;
    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        WBARB_IDLE  = 2'd0,
        WBARB_WAIT  = 2'd1,
        WBARB_FORCE = 2'd2
    } rvga_wbarb_state_e;

    localparam int RVGA_WB_STARVE_LIMIT = 4;

    // x0 is hardwired to zero, so a write to it is never performed.
    function automatic logic rd_writes(input rvga_reg rd);
        return (rd != 5'd0);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: pipeline writeback, aux valid/ready request and the
// registered register-file write port.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    rvga_reg  pipe_rd;
    rvga_word pipe_data;
    logic     pipe_w_v;
    logic     aux_v;
    rvga_reg  aux_rd;
    rvga_word aux_data;
    logic     aux_ready;
    logic     pipe_stall;
    rvga_reg  writeback_rfetch_rd;
    rvga_word writeback_rfetch_rd_data;
    logic     writeback_rfetch_rd_w_v;

    modport master (
        output pipe_rd, pipe_data, pipe_w_v, aux_v, aux_rd, aux_data,
        input  aux_ready, pipe_stall,
        input  writeback_rfetch_rd, writeback_rfetch_rd_data, writeback_rfetch_rd_w_v
    );

    modport slave (
        input  pipe_rd, pipe_data, pipe_w_v, aux_v, aux_rd, aux_data,
        output aux_ready, pipe_stall,
        output writeback_rfetch_rd, writeback_rfetch_rd_data, writeback_rfetch_rd_w_v
    );

endinterface

// File: rtl/wb_port_arbiter_starve_ctr.sv
// Starvation FSM for the aux requester: counts consecutive blocked cycles and
// forces a one-cycle pipeline stall so the pending aux write can drain.
module wb_arb_starve_ctr
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = RVGA_WB_STARVE_LIMIT,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic aux_v,
    input  logic aux_ready,
    output logic pipe_stall
);

    rvga_wbarb_state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_q;
    logic              blocked_s;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blocked_s = aux_v && !aux_ready;
        case (state_q)
            WBARB_IDLE: begin
                if (blocked_s && (STARVE_LIMIT == 1)) begin
                    state_d = WBARB_FORCE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (blocked_s) begin
                    state_d = WBARB_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = WBARB_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            WBARB_WAIT: begin
                if (!blocked_s) begin
                    state_d = WBARB_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q >= CNT_W'(STARVE_LIMIT - 1)) begin
                    // Counter holds its saturated value through FORCE.
                    state_d = WBARB_FORCE;
                    cnt_d   = cnt_q;
                end else begin
                    state_d = WBARB_WAIT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            WBARB_FORCE: begin
                state_d = WBARB_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
            default: begin
                state_d = WBARB_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered stall output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WBARB_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= (state_d == WBARB_FORCE);
        end
    end

    assign pipe_stall = stall_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, aux
// requester is force-granted after STARVE_LIMIT blocked cycles.
// Optional WB_ARB_PERF_EN adds 32-bit pipe/aux/force event counters.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = RVGA_WB_STARVE_LIMIT,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef WB_ARB_PERF_EN
    output logic [31:0]          perf_pipe_wr,
    output logic [31:0]          perf_aux_wr,
    output logic [31:0]          perf_force,
`endif
    wb_port_arbiter_if.slave     bus
);

    logic     pipe_stall_s;
    logic     pipe_req_s;
    logic     aux_ready_s;
    rvga_reg  rd_q, rd_d;
    rvga_word data_q, data_d;
    logic     w_v_q, w_v_d;

    wb_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_ctr (
        .clk        (clk),
        .rst        (rst),
        .aux_v      (bus.aux_v),
        .aux_ready  (aux_ready_s),
        .pipe_stall (pipe_stall_s)
    );

    // Request qualification; pipe_stall is high exactly while in FORCE.
    always_comb begin
        pipe_req_s  = bus.pipe_w_v && !pipe_stall_s && rd_writes(bus.pipe_rd);
        aux_ready_s = bus.aux_v && (pipe_stall_s || !pipe_req_s);
    end

    // Write-port select; an idle cycle keeps rd/data and drops the enable.
    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        w_v_d  = 1'b0;
        if (pipe_req_s) begin
            rd_d   = bus.pipe_rd;
            data_d = bus.pipe_data;
            w_v_d  = 1'b1;
        end else if (aux_ready_s) begin
            rd_d   = bus.aux_rd;
            data_d = bus.aux_data;
            w_v_d  = rd_writes(bus.aux_rd);
        end else begin
            w_v_d  = 1'b0;
        end
    end

    // Register-file write port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= 5'd0;
            data_q <= 32'd0;
            w_v_q  <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            data_q <= data_d;
            w_v_q  <= w_v_d;
        end
    end

    assign bus.aux_ready                = aux_ready_s;
    assign bus.pipe_stall               = pipe_stall_s;
    assign bus.writeback_rfetch_rd      = rd_q;
    assign bus.writeback_rfetch_rd_data = data_q;
    assign bus.writeback_rfetch_rd_w_v  = w_v_q;

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_pipe_q, perf_pipe_d;
    logic [31:0] perf_aux_q,  perf_aux_d;
    logic [31:0] perf_force_q, perf_force_d;

    // Event counters; each FORCE visit lasts one cycle so a stall cycle is an entry.
    always_comb begin
        perf_pipe_d  = perf_pipe_q  + (pipe_req_s   ? 32'd1 : 32'd0);
        perf_aux_d   = perf_aux_q   + (aux_ready_s  ? 32'd1 : 32'd0);
        perf_force_d = perf_force_q + (pipe_stall_s ? 32'd1 : 32'd0);
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_pipe_q  <= 32'd0;
            perf_aux_q   <= 32'd0;
            perf_force_q <= 32'd0;
        end else begin
            perf_pipe_q  <= perf_pipe_d;
            perf_aux_q   <= perf_aux_d;
            perf_force_q <= perf_force_d;
        end
    end

    assign perf_pipe_wr = perf_pipe_q;
    assign perf_aux_wr  = perf_aux_q;
    assign perf_force   = perf_force_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (STARVE_LIMIT=4);
// perf counters are checked when WB_ARB_PERF_EN is defined.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    wb_port_arbiter_if bus_if ();

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_pipe_wr, perf_aux_wr, perf_force;
`endif

    wb_port_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef WB_ARB_PERF_EN
        .perf_pipe_wr (perf_pipe_wr),
        .perf_aux_wr  (perf_aux_wr),
        .perf_force   (perf_force),
`endif
        .bus          (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad);
        bus_if.pipe_w_v  = pw;
        bus_if.pipe_rd   = prd;
        bus_if.pipe_data = pd;
        bus_if.aux_v     = av;
        bus_if.aux_rd    = ard;
        bus_if.aux_data  = ad;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd9, 32'h9999);
        tick();
        tick();
        rst = 1'b0;
        // two blocked cycles put the FSM in WAIT
        tick();
        n_vec++;
        if (bus_if.writeback_rfetch_rd_w_v !== 1'b1 || bus_if.writeback_rfetch_rd !== 5'd2) begin
            n_err++;
            $display("FAIL pre_reset_write got rd=%0d w_v=%b want rd=2 w_v=1",
                     bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_w_v);
        end
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus_if.writeback_rfetch_rd !== 5'd0 || bus_if.writeback_rfetch_rd_data !== 32'd0 ||
            bus_if.writeback_rfetch_rd_w_v !== 1'b0 || bus_if.pipe_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got rd=%0d data=%h w_v=%b stall=%b want all 0",
                     bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                     bus_if.writeback_rfetch_rd_w_v, bus_if.pipe_stall);
        end
        n_vec++;
        if (bus_if.aux_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_pipe got aux_ready=%b want 0", bus_if.aux_ready);
        end
        drive(1'b0, 5'd2, 32'h2222, 1'b1, 5'd9, 32'h9999);
        n_vec++;
        if (bus_if.aux_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_idle got aux_ready=%b want 1", bus_if.aux_ready);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_pipe_only();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0);
        n_vec++;
        if (bus_if.writeback_rfetch_rd !== 5'd5 || bus_if.writeback_rfetch_rd_data !== 32'hDEADBEEF ||
            bus_if.writeback_rfetch_rd_w_v !== 1'b1) begin
            n_err++;
            $display("FAIL pipe_write got rd=%0d data=%h w_v=%b want rd=5 data=deadbeef w_v=1",
                     bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                     bus_if.writeback_rfetch_rd_w_v);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_vec++;
        if (bus_if.writeback_rfetch_rd_w_v !== 1'b0 || bus_if.writeback_rfetch_rd !== 5'd5 ||
            bus_if.writeback_rfetch_rd_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL pipe_x0 got rd=%0d data=%h w_v=%b want rd=5 data=deadbeef w_v=0",
                     bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                     bus_if.writeback_rfetch_rd_w_v);
        end
    endtask

    task automatic test_aux_idle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12);
        n_vec++;
        if (bus_if.aux_ready !== 1'b1) begin
            n_err++;
            $display("FAIL aux_idle_ready got %b want 1", bus_if.aux_ready);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
        n_vec++;
        if (bus_if.writeback_rfetch_rd !== 5'd7 || bus_if.writeback_rfetch_rd_data !== 32'h12 ||
            bus_if.writeback_rfetch_rd_w_v !== 1'b1) begin
            n_err++;
            $display("FAIL aux_idle_write got rd=%0d data=%h w_v=%b want rd=7 data=12 w_v=1",
                     bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                     bus_if.writeback_rfetch_rd_w_v);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_vec++;
        if (bus_if.writeback_rfetch_rd_w_v !== 1'b0) begin
            n_err++;
            $display("FAIL aux_x0 got w_v=%b want 0", bus_if.writeback_rfetch_rd_w_v);
        end
    endtask

    task automatic test_same_rd();
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
        n_vec++;
        if (bus_if.aux_ready !== 1'b0) begin
            n_err++;
            $display("FAIL same_rd_block got aux_ready=%b want 0", bus_if.aux_ready);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hB);
        n_vec++;
        if (bus_if.writeback_rfetch_rd !== 5'd3 || bus_if.writeback_rfetch_rd_data !== 32'hA ||
            bus_if.writeback_rfetch_rd_w_v !== 1'b1 || bus_if.aux_ready !== 1'b1) begin
            n_err++;
            $display("FAIL same_rd_first got rd=%0d data=%h w_v=%b ready=%b want rd=3 data=a w_v=1 ready=1",
                     bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                     bus_if.writeback_rfetch_rd_w_v, bus_if.aux_ready);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_vec++;
        if (bus_if.writeback_rfetch_rd !== 5'd3 || bus_if.writeback_rfetch_rd_data !== 32'hB ||
            bus_if.writeback_rfetch_rd_w_v !== 1'b1) begin
            n_err++;
            $display("FAIL same_rd_second got rd=%0d data=%h w_v=%b want rd=3 data=b w_v=1",
                     bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                     bus_if.writeback_rfetch_rd_w_v);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [4:0]  prd;
        logic [31:0] pd;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            prd = (i <= 3) ? 5'(i + 1) : ((i == 4) ? 5'd20 : 5'd21);
            pd  = (i <= 3) ? 32'h100 + 32'(i) : ((i == 4) ? 32'h555 : 32'h600);
            drive(1'b1, prd, pd, (i <= 4), 5'd9, 32'h99);
            n_vec++;
            if (bus_if.aux_ready !== (i == 4) || bus_if.pipe_stall !== (i == 4)) begin
                n_err++;
                $display("FAIL starve_ctl cycle %0d got ready=%b stall=%b want %b",
                         i, bus_if.aux_ready, bus_if.pipe_stall, (i == 4));
            end
            if (i >= 1 && i <= 4) begin
                n_vec++;
                if (bus_if.writeback_rfetch_rd !== 5'(i) ||
                    bus_if.writeback_rfetch_rd_data !== 32'h100 + 32'(i - 1) ||
                    bus_if.writeback_rfetch_rd_w_v !== 1'b1) begin
                    n_err++;
                    $display("FAIL starve_pipe cycle %0d got rd=%0d data=%h w_v=%b want rd=%0d data=%h",
                             i, bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                             bus_if.writeback_rfetch_rd_w_v, i, 32'h100 + 32'(i - 1));
                end
            end
            if (i == 5) begin
                n_vec++;
                if (bus_if.writeback_rfetch_rd !== 5'd9 || bus_if.writeback_rfetch_rd_data !== 32'h99 ||
                    bus_if.writeback_rfetch_rd_w_v !== 1'b1) begin
                    n_err++;
                    $display("FAIL starve_aux got rd=%0d data=%h w_v=%b want rd=9 data=99 w_v=1",
                             bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                             bus_if.writeback_rfetch_rd_w_v);
                end
`ifdef WB_ARB_PERF_EN
                n_vec++;
                if (perf_force !== 32'd1 || perf_aux_wr !== 32'd1 || perf_pipe_wr !== 32'd4) begin
                    n_err++;
                    $display("FAIL perf got force=%0d aux=%0d pipe=%0d want 1 1 4",
                             perf_force, perf_aux_wr, perf_pipe_wr);
                end
`endif
            end
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        n_vec++;
        if (bus_if.writeback_rfetch_rd !== 5'd21 || bus_if.writeback_rfetch_rd_data !== 32'h600 ||
            bus_if.writeback_rfetch_rd_w_v !== 1'b1 || bus_if.pipe_stall !== 1'b0) begin
            n_err++;
            $display("FAIL starve_resume got rd=%0d data=%h w_v=%b stall=%b want rd=21 data=600 w_v=1 stall=0",
                     bus_if.writeback_rfetch_rd, bus_if.writeback_rfetch_rd_data,
                     bus_if.writeback_rfetch_rd_w_v, bus_if.pipe_stall);
        end
        tick();
    endtask

    initial begin
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_pipe_only();
        test_aux_idle();
        test_same_rd();
        test_starvation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
